// File: rtl/mem_bus_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_decoder_if
// Purpose  : Bundles the core-side valid/ready memory bus and the fanned-out
//            per-slave handshake used by mem_bus_decoder.
// Signals  : mem_valid/mem_addr  - core request (held until mem_ready)
//            mem_ready/mem_rdata - response strobe and read data to the core
//            s_valid             - per-slave request, one-hot or zero
//            s_ready/s_rdata     - per-slave ready and read data
//                                  (slave i data at [32*i+31:32*i])
// Modports : slave  - the decoder's view
//            master - the environment's view (core plus attached slaves)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bus_decoder_if #(
  parameter int unsigned NSLAVES = 3
);
  logic                    mem_valid;
  logic                    mem_ready;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_rdata;
  logic [NSLAVES-1:0]      s_valid;
  logic [NSLAVES-1:0]      s_ready;
  logic [32*NSLAVES-1:0]   s_rdata;

  modport slave (
    input  mem_valid, mem_addr, s_ready, s_rdata,
    output mem_ready, mem_rdata, s_valid
  );

  modport master (
    output mem_valid, mem_addr, s_ready, s_rdata,
    input  mem_ready, mem_rdata, s_valid
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_decoder
// Purpose  : N-slave address decoder and response mux for the valid/ready
//            memory bus. Registers a one-hot slave select and answers with an
//            error response for unmapped addresses or slaves that time out.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            bus (slave)     - core bus and per-slave handshake
//            err_o           - sticky error flag
//            err_addr_o      - address of the first error since last clear
//            err_clear_i     - clears err_o and err_addr_o
//            timeout_evt_o   - one-cycle pulse on each slave timeout
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_decoder #(
  parameter int unsigned           NSLAVES     = 3,
  parameter logic [16*NSLAVES-1:0] SLAVE_BASES = {16'h0300, 16'h0000, 16'h0005},
  parameter int unsigned           TIMEOUT     = 15,
  parameter logic [31:0]           ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_bus_decoder_if.slave        bus,
  output logic                    err_o,
  output logic [31:0]             err_addr_o,
  input  logic                    err_clear_i,
  output logic                    timeout_evt_o
);

  localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last ACTIVE cycle before the timeout fires.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t              state_q,   state_d;
  logic [NSLAVES-1:0]  sel_q,     sel_d;
  logic [NSLAVES-1:0]  s_valid_q, s_valid_d;
  logic [CW-1:0]       cnt_q,     cnt_d;
  logic                tevt_q,    tevt_d;
  logic                err_q,     err_d;
  logic [31:0]         err_addr_q, err_addr_d;

  logic [NSLAVES-1:0]  w_match;
  logic [NSLAVES-1:0]  w_hit_oh;
  logic                w_any_hit;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;
  logic                w_mem_ready;
  logic [31:0]         w_mem_rdata;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_match
    assign w_match[gi] = (bus.mem_addr[31:16] == SLAVE_BASES[16*gi +: 16]);
  end

  // Isolating the lowest set bit gives lowest-index-wins on overlapping bases.
  assign w_hit_oh  = w_match & (~w_match + NSLAVES'(1));
  assign w_any_hit = |w_match;

  // --------------------------------------------------------------------------
  // Response mux; sel_q is one-hot so an AND-OR mux suffices.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      w_sel_ready = w_sel_ready | (bus.s_ready[i] & sel_q[i]);
      w_sel_rdata = w_sel_rdata | (bus.s_rdata[32*i +: 32] & {32{sel_q[i]}});
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and response outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    s_valid_d   = s_valid_q;
    cnt_d       = cnt_q;
    tevt_d      = 1'b0;
    w_mem_ready = 1'b0;
    w_mem_rdata = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.mem_valid) begin
          if (w_any_hit) begin
            sel_d     = w_hit_oh;
            s_valid_d = w_hit_oh;
            state_d   = ST_ACTIVE;
          end else begin
            state_d   = ST_ERR;
          end
        end
      end

      ST_ACTIVE: begin
        w_mem_ready = w_sel_ready;
        w_mem_rdata = w_sel_rdata;
        if (w_sel_ready || !bus.mem_valid) begin
          // Normal completion or master abort: back to idle, no error.
          state_d   = ST_IDLE;
          sel_d     = '0;
          s_valid_d = '0;
          cnt_d     = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d   = ST_ERR;
          sel_d     = '0;
          s_valid_d = '0;
          cnt_d     = '0;
          tevt_d    = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_ERR: begin
        w_mem_ready = 1'b1;
        w_mem_rdata = ERR_DATA;
        s_valid_d   = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        sel_d     = '0;
        s_valid_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky error capture. Only the first error since the last clear records
  // its address; a capture coinciding with err_clear_i takes precedence.
  // --------------------------------------------------------------------------
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if ((state_q == ST_ERR) && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = bus.mem_addr;
    end else if (err_clear_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      s_valid_q  <= '0;
      cnt_q      <= '0;
      tevt_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      s_valid_q  <= s_valid_d;
      cnt_q      <= cnt_d;
      tevt_q     <= tevt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.s_valid   = s_valid_q;
  assign bus.mem_ready = w_mem_ready;
  assign bus.mem_rdata = w_mem_rdata;
  assign err_o         = err_q;
  assign err_addr_o    = err_addr_q;
  assign timeout_evt_o = tevt_q;

endmodule
`default_nettype wire
